// File: rtl/frame_metric_pkg.sv
// frame_metric_pkg: shared state encoding, width helper and default word width for frame metrics
package frame_metric_pkg;
    localparam int Q88_W = 16;
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SCAN   = 2'd1;
    localparam logic [1:0] S_DIVIDE = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;
    // bits needed to index v items, never less than one
    function automatic int clog2w(input int v);
        int w = 1;
        while ((1 << w) < v) w++;
        return w;
    endfunction
endpackage

// File: rtl/seq_udiv.sv
// seq_udiv: restoring unsigned divider, one quotient bit per cycle, N_W cycles per divide
// ports: clk, rst (async, active high); start loads dividend/divisor when idle;
//        busy while iterating; done pulses one cycle with quotient valid
module seq_udiv
    import frame_metric_pkg::*;
#(
    parameter int N_W = 27,
    parameter int D_W = 11
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [N_W-1:0] dividend,
    input  logic [D_W-1:0] divisor,
    output logic           busy,
    output logic           done,
    output logic [N_W-1:0] quotient
);
    localparam int CNT_W = clog2w(N_W + 1);
    logic [D_W-1:0] rem_q, rem_d, dvs_q, dvs_d;
    logic [N_W-1:0] quo_q, quo_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic busy_q, busy_d, done_q, done_d;
    logic [D_W:0] rem_sh;
    logic ge;
    // dividend bits shift out of the quotient register into the remainder as quotient bits shift in
    assign rem_sh = {rem_q, quo_q[N_W-1]};
    assign ge = rem_sh >= {1'b0, dvs_q};
    always_comb begin
        rem_d = rem_q;
        quo_d = quo_q;
        dvs_d = dvs_q;
        cnt_d = cnt_q;
        busy_d = busy_q;
        done_d = 1'b0;
        if (start && !busy_q) begin
            rem_d = '0;
            quo_d = dividend;
            dvs_d = divisor;
            cnt_d = CNT_W'(N_W);
            busy_d = 1'b1;
        end else if (busy_q) begin
            rem_d = ge ? D_W'(rem_sh - {1'b0, dvs_q}) : rem_sh[D_W-1:0];
            quo_d = {quo_q[N_W-2:0], ge};
            cnt_d = cnt_q - 1'b1;
            busy_d = cnt_q != CNT_W'(1);
            done_d = cnt_q == CNT_W'(1);
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
            cnt_q <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            dvs_q <= dvs_d;
            cnt_q <= cnt_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end
    assign busy = busy_q;
    assign done = done_q;
    assign quotient = quo_q;
endmodule

// File: rtl/frame_similarity_engine.sv
// frame_similarity_engine: abs-difference metrics (sum, max, argmax, mismatches, average) of two flat frames
// ports: clk, rst (async, active high); start with signed_mode/tolerance sampled on accept;
//        frame_a_flat/frame_b_flat held stable while busy; busy, done pulse, result_valid;
//        sum_abs, max_abs, max_idx, mismatch_count, avg_abs hold until the next run completes
module frame_similarity_engine
    import frame_metric_pkg::*;
#(
    parameter int PIXEL_COUNT = 784,
    parameter int DATA_W = Q88_W,
    parameter int LANES = 4,
    localparam int BEATS = PIXEL_COUNT / LANES,
    localparam int ABS_W = DATA_W + 1,
    localparam int IDX_W = clog2w(PIXEL_COUNT),
    localparam int SUM_W = ABS_W + IDX_W
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          signed_mode,
    input  logic [ABS_W-1:0]              tolerance,
    input  logic [DATA_W*PIXEL_COUNT-1:0] frame_a_flat,
    input  logic [DATA_W*PIXEL_COUNT-1:0] frame_b_flat,
    output logic                          busy,
    output logic                          done,
    output logic                          result_valid,
    output logic [SUM_W-1:0]              sum_abs,
    output logic [ABS_W-1:0]              max_abs,
    output logic [IDX_W-1:0]              max_idx,
    output logic [IDX_W:0]                mismatch_count,
    output logic [SUM_W-1:0]              avg_abs
);
    localparam int BEAT_W = clog2w(BEATS);
    if (PIXEL_COUNT % LANES != 0) begin : g_bad_lanes
        $fatal(1, "PIXEL_COUNT must be a multiple of LANES");
    end
    logic [1:0] state_q, state_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic signed_q, signed_d;
    logic [ABS_W-1:0] tol_q, tol_d;
    logic [SUM_W-1:0] sum_acc_q, sum_acc_d;
    logic [ABS_W-1:0] max_acc_q, max_acc_d;
    logic [IDX_W-1:0] idx_acc_q, idx_acc_d;
    logic [IDX_W:0] mis_acc_q, mis_acc_d;
    logic busy_q, busy_d, done_q, done_d, valid_q, valid_d;
    logic [SUM_W-1:0] sum_out_q, sum_out_d, avg_out_q, avg_out_d;
    logic [ABS_W-1:0] max_out_q, max_out_d;
    logic [IDX_W-1:0] idx_out_q, idx_out_d;
    logic [IDX_W:0] mis_out_q, mis_out_d;
    logic [BEATS-1:0][LANES-1:0][DATA_W-1:0] a_v, b_v;
    logic [ABS_W-1:0] lane_abs [LANES];
    logic [SUM_W-1:0] beat_sum;
    logic [ABS_W-1:0] beat_max;
    logic [IDX_W-1:0] beat_idx;
    logic [IDX_W:0] beat_mis;
    logic last_beat, div_start, div_busy, div_done;
    logic [SUM_W-1:0] div_quo;
    assign a_v = frame_a_flat;
    assign b_v = frame_b_flat;
    assign last_beat = beat_q == BEAT_W'(BEATS - 1);
    // two guard bits keep the difference of two extended words exact in either mode
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [ABS_W:0] ea, eb, df;
        assign ea = {{2{signed_q & a_v[beat_q][l][DATA_W-1]}}, a_v[beat_q][l]};
        assign eb = {{2{signed_q & b_v[beat_q][l][DATA_W-1]}}, b_v[beat_q][l]};
        assign df = ea - eb;
        assign lane_abs[l] = df[ABS_W] ? ABS_W'(-df) : df[ABS_W-1:0];
    end
    // running max starts from the accumulator and only moves on strictly greater, so ties keep the lowest index
    always_comb begin
        beat_sum = '0;
        beat_max = max_acc_q;
        beat_idx = idx_acc_q;
        beat_mis = '0;
        for (int l = 0; l < LANES; l++) begin
            beat_sum = beat_sum + SUM_W'(lane_abs[l]);
            beat_mis = beat_mis + (IDX_W+1)'(lane_abs[l] > tol_q);
            if (lane_abs[l] > beat_max) begin
                beat_max = lane_abs[l];
                beat_idx = IDX_W'(int'(beat_q) * LANES + l);
            end
        end
    end
    always_comb begin
        state_d = (state_q == S_IDLE && start) ? S_SCAN :
                  (state_q == S_SCAN && last_beat) ? S_DIVIDE :
                  (state_q == S_DIVIDE && div_done) ? S_DONE :
                  (state_q == S_DONE) ? S_IDLE : state_q;
    end
    // the divider is loaded on the last scan edge with the final sum so it finishes inside DIVIDE
    always_comb begin
        beat_d = beat_q;
        signed_d = signed_q;
        tol_d = tol_q;
        sum_acc_d = sum_acc_q;
        max_acc_d = max_acc_q;
        idx_acc_d = idx_acc_q;
        mis_acc_d = mis_acc_q;
        busy_d = busy_q;
        done_d = 1'b0;
        valid_d = valid_q;
        sum_out_d = sum_out_q;
        max_out_d = max_out_q;
        idx_out_d = idx_out_q;
        mis_out_d = mis_out_q;
        avg_out_d = avg_out_q;
        div_start = 1'b0;
        if (state_q == S_IDLE && start) begin
            signed_d = signed_mode;
            tol_d = tolerance;
            sum_acc_d = '0;
            max_acc_d = '0;
            idx_acc_d = '0;
            mis_acc_d = '0;
            beat_d = '0;
            valid_d = 1'b0;
            busy_d = 1'b1;
        end
        if (state_q == S_SCAN) begin
            sum_acc_d = sum_acc_q + beat_sum;
            max_acc_d = beat_max;
            idx_acc_d = beat_idx;
            mis_acc_d = mis_acc_q + beat_mis;
            beat_d = last_beat ? '0 : beat_q + 1'b1;
            div_start = last_beat && !div_busy;
        end
        if (state_q == S_DONE) begin
            sum_out_d = sum_acc_q;
            max_out_d = max_acc_q;
            idx_out_d = idx_acc_q;
            mis_out_d = mis_acc_q;
            avg_out_d = div_quo;
            valid_d = 1'b1;
            done_d = 1'b1;
            busy_d = 1'b0;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            beat_q <= '0;
            signed_q <= 1'b0;
            tol_q <= '0;
            sum_acc_q <= '0;
            max_acc_q <= '0;
            idx_acc_q <= '0;
            mis_acc_q <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            valid_q <= 1'b0;
            sum_out_q <= '0;
            max_out_q <= '0;
            idx_out_q <= '0;
            mis_out_q <= '0;
            avg_out_q <= '0;
        end else begin
            state_q <= state_d;
            beat_q <= beat_d;
            signed_q <= signed_d;
            tol_q <= tol_d;
            sum_acc_q <= sum_acc_d;
            max_acc_q <= max_acc_d;
            idx_acc_q <= idx_acc_d;
            mis_acc_q <= mis_acc_d;
            busy_q <= busy_d;
            done_q <= done_d;
            valid_q <= valid_d;
            sum_out_q <= sum_out_d;
            max_out_q <= max_out_d;
            idx_out_q <= idx_out_d;
            mis_out_q <= mis_out_d;
            avg_out_q <= avg_out_d;
        end
    end
    seq_udiv #(.N_W(SUM_W), .D_W(IDX_W + 1)) u_div (
        .clk      (clk),
        .rst      (rst),
        .start    (div_start),
        .dividend (sum_acc_d),
        .divisor  ((IDX_W+1)'(PIXEL_COUNT)),
        .busy     (div_busy),
        .done     (div_done),
        .quotient (div_quo)
    );
    assign busy = busy_q;
    assign done = done_q;
    assign result_valid = valid_q;
    assign sum_abs = sum_out_q;
    assign max_abs = max_out_q;
    assign max_idx = idx_out_q;
    assign mismatch_count = mis_out_q;
    assign avg_abs = avg_out_q;
endmodule

// File: tb/tb_frame_similarity_engine.sv
// tb_frame_similarity_engine: scoreboard bench for a default-size and an 8-pixel engine
module tb_frame_similarity_engine;
    localparam int NB = 784;
    localparam int NS = 8;
    localparam int DW = 16;
    localparam int BIGW = NB * DW;
    localparam int LAT_B = NB / 4 + (17 + 10) + 2;
    localparam int LAT_S = NS / 2 + (17 + 3) + 2;
    typedef struct {
        int s;
        int m;
        int i;
        int c;
        int a;
        int cy;
    } exp_t;
    logic clk = 1'b0;
    logic rst;
    logic start_b, sm_b, busy_b, done_b, valid_b;
    logic [16:0] tol_b, max_b;
    logic [BIGW-1:0] fa_b, fb_b;
    logic [26:0] sum_b, avg_b;
    logic [9:0] idx_b;
    logic [10:0] mis_b;
    logic start_s, sm_s, busy_s, done_s, valid_s;
    logic [16:0] tol_s, max_s;
    logic [NS*DW-1:0] fa_s, fb_s;
    logic [19:0] sum_s, avg_s;
    logic [2:0] idx_s;
    logic [3:0] mis_s;
    int errors = 0;
    int checks = 0;
    int cyc = 0;
    exp_t qb[$];
    exp_t qs[$];
    exp_t eb, es;
    logic prev_b = 1'b0;
    logic prev_s = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    frame_similarity_engine u_big (
        .clk(clk), .rst(rst), .start(start_b), .signed_mode(sm_b), .tolerance(tol_b),
        .frame_a_flat(fa_b), .frame_b_flat(fb_b), .busy(busy_b), .done(done_b),
        .result_valid(valid_b), .sum_abs(sum_b), .max_abs(max_b), .max_idx(idx_b),
        .mismatch_count(mis_b), .avg_abs(avg_b)
    );
    frame_similarity_engine #(.PIXEL_COUNT(NS), .LANES(2)) u_small (
        .clk(clk), .rst(rst), .start(start_s), .signed_mode(sm_s), .tolerance(tol_s),
        .frame_a_flat(fa_s), .frame_b_flat(fb_s), .busy(busy_s), .done(done_s),
        .result_valid(valid_s), .sum_abs(sum_s), .max_abs(max_s), .max_idx(idx_s),
        .mismatch_count(mis_s), .avg_abs(avg_s)
    );
    task automatic chk(input string n, input int act, input int want);
        checks++;
        if (act != want) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", n, act, want);
        end
    endtask
    function automatic exp_t mk(input int s, input int m, input int i, input int c, input int a);
        exp_t e;
        e.s = s;
        e.m = m;
        e.i = i;
        e.c = c;
        e.a = a;
        e.cy = 0;
        return e;
    endfunction
    // reference: direct arithmetic on pixel values interpreted per mode
    function automatic exp_t model(input logic [BIGW-1:0] fa, input logic [BIGW-1:0] fb,
                                   input int n, input logic sm, input int tol);
        exp_t e = mk(0, 0, 0, 0, 0);
        for (int i = 0; i < n; i++) begin
            int a = sm ? int'($signed(fa[i*DW +: DW])) : int'(fa[i*DW +: DW]);
            int b = sm ? int'($signed(fb[i*DW +: DW])) : int'(fb[i*DW +: DW]);
            int d = a > b ? a - b : b - a;
            e.s += d;
            if (d > e.m) begin
                e.m = d;
                e.i = i;
            end
            if (d > tol) e.c++;
        end
        e.a = e.s / n;
        return e;
    endfunction
    task automatic fill(input int n, output logic [BIGW-1:0] a, output logic [BIGW-1:0] b);
        a = '0;
        b = '0;
        for (int i = 0; i < n; i++) begin
            logic [15:0] x = 16'($urandom);
            int k = $urandom_range(0, 2);
            a[i*DW +: DW] = x;
            b[i*DW +: DW] = k == 0 ? 16'($urandom) : k == 1 ? x + 16'($urandom_range(0, 3)) : x;
        end
    endtask
    function automatic logic [16:0] rand_tol();
        return $urandom_range(0, 3) == 0 ? 17'($urandom_range(0, 131071)) : 17'($urandom_range(0, 4));
    endfunction
    task automatic wait_idle(input logic big);
        int n = 0;
        while ((big ? (busy_b || qb.size() != 0) : (busy_s || qs.size() != 0)) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) begin
            errors++;
            checks++;
            $display("FAIL %s_timeout: still busy after %0d cycles, want idle", big ? "big" : "small", n);
        end
    endtask
    task automatic go_b(input logic sm, input logic [16:0] t, input exp_t e);
        @(negedge clk);
        sm_b = sm;
        tol_b = t;
        start_b = 1'b1;
        @(posedge clk);
        #1;
        start_b = 1'b0;
        e.cy = cyc + LAT_B;
        qb.push_back(e);
    endtask
    task automatic go_s(input logic sm, input logic [16:0] t, input exp_t e, input logic push);
        @(negedge clk);
        sm_s = sm;
        tol_s = t;
        start_s = 1'b1;
        @(posedge clk);
        #1;
        start_s = 1'b0;
        e.cy = cyc + LAT_S;
        if (push) qs.push_back(e);
    endtask
    task automatic set_tie();
        for (int i = 0; i < NS; i++) begin
            fa_s[i*DW +: DW] = 16'h0100;
            fb_s[i*DW +: DW] = i == 3 ? 16'h0000 : i == 5 ? 16'h0200 : 16'h0100;
        end
    endtask
    task automatic set_sign();
        for (int i = 0; i < NS; i++) begin
            fa_s[i*DW +: DW] = i == 6 ? 16'h8000 : 16'h0100;
            fb_s[i*DW +: DW] = i == 6 ? 16'h7FFF : 16'h0100;
        end
    endtask
    always @(negedge clk) begin
        if (!rst && done_b) begin
            chk("big_done_width", int'(prev_b), 0);
            if (qb.size() == 0) begin
                errors++;
                checks++;
                $display("FAIL big_unexpected_done: got done at cycle %0d, want none", cyc);
            end else begin
                eb = qb.pop_front();
                chk("big_cycle", cyc, eb.cy);
                chk("big_valid", int'(valid_b), 1);
                chk("big_sum", int'(sum_b), eb.s);
                chk("big_max", int'(max_b), eb.m);
                chk("big_idx", int'(idx_b), eb.i);
                chk("big_mis", int'(mis_b), eb.c);
                chk("big_avg", int'(avg_b), eb.a);
            end
        end
        prev_b <= done_b;
    end
    always @(negedge clk) begin
        if (!rst && done_s) begin
            chk("small_done_width", int'(prev_s), 0);
            if (qs.size() == 0) begin
                errors++;
                checks++;
                $display("FAIL small_unexpected_done: got done at cycle %0d, want none", cyc);
            end else begin
                es = qs.pop_front();
                chk("small_cycle", cyc, es.cy);
                chk("small_valid", int'(valid_s), 1);
                chk("small_sum", int'(sum_s), es.s);
                chk("small_max", int'(max_s), es.m);
                chk("small_idx", int'(idx_s), es.i);
                chk("small_mis", int'(mis_s), es.c);
                chk("small_avg", int'(avg_s), es.a);
            end
        end
        prev_s <= done_s;
    end
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, want completion");
        $fatal(1, "watchdog");
    end
    initial begin
        logic [BIGW-1:0] wa, wb;
        logic [16:0] t;
        logic sm;
        int low = 0;
        int acc;
        exp_t e;
        rst = 1'b1;
        start_b = 1'b0;
        start_s = 1'b0;
        sm_b = 1'b0;
        sm_s = 1'b0;
        tol_b = '0;
        tol_s = '0;
        fa_b = '0;
        fb_b = '0;
        fa_s = '0;
        fb_s = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", int'(busy_b), 0);
        chk("rst_done", int'(done_b), 0);
        chk("rst_valid", int'(valid_b), 0);
        chk("rst_sum", int'(sum_b), 0);
        chk("rst_max", int'(max_s), 0);
        chk("rst_idx", int'(idx_s), 0);
        chk("rst_mis", int'(mis_s), 0);
        chk("rst_avg", int'(avg_s), 0);
        rst = 1'b0;
        fill(NB, wa, wb);
        fa_b = wa;
        fb_b = wa;
        go_b(1'b1, '0, mk(0, 0, 0, 0, 0));
        repeat (LAT_B - 1) @(negedge clk) low += int'(!busy_b);
        chk("big_busy_held", low, 0);
        repeat (2) begin
            wait_idle(1'b1);
            fill(NB, wa, wb);
            fa_b = wa;
            fb_b = wb;
            sm = 1'($urandom);
            t = rand_tol();
            go_b(sm, t, model(fa_b, fb_b, NB, sm, int'(t)));
        end
        wait_idle(1'b1);
        wait_idle(1'b0);
        set_tie();
        go_s(1'b0, 17'd0, mk(512, 256, 3, 2, 64), 1'b1);
        wait_idle(1'b0);
        go_s(1'b0, 17'd256, mk(512, 256, 3, 0, 64), 1'b1);
        wait_idle(1'b0);
        go_s(1'b0, 17'd255, mk(512, 256, 3, 2, 64), 1'b1);
        wait_idle(1'b0);
        set_sign();
        go_s(1'b1, 17'd0, mk(65535, 65535, 6, 1, 8191), 1'b1);
        wait_idle(1'b0);
        go_s(1'b0, 17'd0, mk(1, 1, 6, 1, 0), 1'b1);
        wait_idle(1'b0);
        set_tie();
        go_s(1'b0, 17'd0, mk(512, 256, 3, 2, 64), 1'b1);
        @(negedge clk);
        start_s = 1'b1;
        @(negedge clk);
        start_s = 1'b0;
        wait_idle(1'b0);
        go_s(1'b0, 17'd0, mk(0, 0, 0, 0, 0), 1'b0);
        repeat (NS / 2 + 5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_busy", int'(busy_s), 0);
        chk("abort_valid", int'(valid_s), 0);
        chk("abort_sum", int'(sum_s), 0);
        chk("abort_max", int'(max_s), 0);
        chk("abort_mis", int'(mis_s), 0);
        chk("abort_avg", int'(avg_s), 0);
        chk("abort_big_valid", int'(valid_b), 0);
        rst = 1'b0;
        go_s(1'b0, 17'd0, mk(512, 256, 3, 2, 64), 1'b1);
        wait_idle(1'b0);
        @(negedge clk);
        sm_s = 1'b0;
        tol_s = '0;
        start_s = 1'b1;
        @(posedge clk);
        #1;
        acc = cyc;
        for (int k = 0; k < 3; k++) begin
            e = mk(512, 256, 3, 2, 64);
            e.cy = acc + LAT_S + k * (LAT_S + 1);
            qs.push_back(e);
        end
        repeat (56) @(negedge clk);
        start_s = 1'b0;
        repeat (20) begin
            wait_idle(1'b0);
            fill(NS, wa, wb);
            fa_s = wa[NS*DW-1:0];
            fb_s = wb[NS*DW-1:0];
            sm = 1'($urandom);
            t = rand_tol();
            go_s(sm, t, model(wa, wb, NS, sm, int'(t)), 1'b1);
        end
        wait_idle(1'b0);
        wait_idle(1'b1);
        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
